// File: rtl/mem_access_pkg.sv
// Shared constants and types for the mem_access stage: opcodes, funct3 codes,
// the bubble PC marker, FSM / pipeline-control encodings and the MEM/WB result record.
package mem_access_pkg;

    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_STORE   = 7'b0100011;

    localparam logic [2:0]  F3_B       = 3'b000;
    localparam logic [2:0]  F3_H       = 3'b001;
    localparam logic [2:0]  F3_W       = 3'b010;
    localparam logic [2:0]  F3_D       = 3'b011;
    localparam logic [2:0]  F3_BU      = 3'b100;
    localparam logic [2:0]  F3_HU      = 3'b101;
    localparam logic [2:0]  F3_WU      = 3'b110;

    localparam logic [63:0] INVALID_PC = 64'h0;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_REQ  = 2'd1,
        MEM_ST_WAIT = 2'd2,
        MEM_ST_DONE = 2'd3
    } mem_st_e;

    typedef enum logic [1:0] {
        CTRL_STATE_Normal = 2'd0,
        CTRL_STATE_Block  = 2'd1,
        CTRL_STATE_Flush  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wreg;
        logic [63:0] wdata;
        logic [63:0] pc;
    } mem_res_t;

    // sz is funct3[1:0]: 0 byte, 1 half, 2 word, 3 doubleword
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'd1:    return off[0];
            2'd2:    return off[1:0] != 2'b00;
            2'd3:    return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load data extraction: selects the addressed byte/half/word from the returned
// doubleword and sign- or zero-extends it to 64 bits.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] result_o
);

    logic [31:0] sh;

    assign sh = 32'(rdata_i >> {off_i, 3'b000});

    always_comb begin
        case (funct3_i)
            F3_B:    result_o = {{56{sh[7]}},  sh[7:0]};
            F3_H:    result_o = {{48{sh[15]}}, sh[15:0]};
            F3_W:    result_o = {{32{sh[31]}}, sh[31:0]};
            F3_BU:   result_o = {56'b0, sh[7:0]};
            F3_HU:   result_o = {48'b0, sh[15:0]};
            F3_WU:   result_o = {32'b0, sh[31:0]};
            F3_D:    result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV64I memory-access stage: drives the data bus, stalls the pipeline while an
// access is in flight and registers the MEM/WB result. Option: MEM_MISALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_addr_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [STRB_W-1:0] dmem_wstrb_o,
    input  logic              dmem_ready_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              stall_req_o,
    output logic [4:0]        rd_addr_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              misalign_o
);

    mem_st_e         state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    mem_res_t        res_q, res_d;
    logic            mis_q, mis_d;

    logic [2:0]      off;
    logic            is_load, is_store, is_mem, bad_f3, misal;
    logic [XLEN-1:0] ld_val;

    assign off      = wdata_i[2:0];
    assign is_load  = (opcode_i == OP_LOAD);
    assign is_store = (opcode_i == OP_STORE);
    assign is_mem   = (is_load || is_store) && (pc_i != INVALID_PC);
    assign bad_f3   = is_store && funct3_i[2];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misal = !bad_f3 && misaligned(funct3_i[1:0], off);
`else
    assign misal = 1'b0;
`endif

    load_extend u_ext (
        .rdata_i  (rdata_q),
        .off_i    (off),
        .funct3_i (funct3_i),
        .result_o (ld_val)
    );

    // Lane placement: narrow data is replicated so every strobed lane sees it
    always_comb begin
        dmem_wstrb_o = '1;
        dmem_wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'd0: begin
                dmem_wstrb_o = STRB_W'(1) << off;
                dmem_wdata_o = {8{store_data_i[7:0]}};
            end
            2'd1: begin
                dmem_wstrb_o = STRB_W'(3) << off;
                dmem_wdata_o = {4{store_data_i[15:0]}};
            end
            2'd2: begin
                dmem_wstrb_o = STRB_W'(8'h0F) << off;
                dmem_wdata_o = {2{store_data_i[31:0]}};
            end
            default: begin
                dmem_wstrb_o = '1;
                dmem_wdata_o = store_data_i;
            end
        endcase
    end

    assign dmem_req_o  = (state_q == MEM_ST_REQ);
    assign dmem_we_o   = dmem_req_o && is_store;
    assign dmem_addr_o = {wdata_i[XLEN-1:3], 3'b000};
    assign stall_req_o = ((state_q == MEM_ST_IDLE) && is_mem) ||
                         (state_q == MEM_ST_REQ) || (state_q == MEM_ST_WAIT);

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            MEM_ST_IDLE: if (is_mem) state_d = (bad_f3 || misal) ? MEM_ST_DONE : MEM_ST_REQ;
            MEM_ST_REQ:  if (dmem_ready_i) state_d = is_store ? MEM_ST_DONE : MEM_ST_WAIT;
            MEM_ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = MEM_ST_DONE;
                end
            end
            MEM_ST_DONE: state_d = MEM_ST_IDLE;
            default:     state_d = MEM_ST_IDLE;
        endcase
    end

    // Result defaults to a bubble; only pass-through and DONE write real values
    always_comb begin
        res_d = '{rd: 5'd0, wreg: 1'b0, wdata: 64'd0, pc: INVALID_PC};
        mis_d = 1'b0;
        case (state_q)
            MEM_ST_IDLE: begin
                if (!is_mem) res_d = '{rd: rd_addr_i, wreg: wreg_i, wdata: wdata_i, pc: pc_i};
            end
            MEM_ST_DONE: begin
                if (misal) begin
                    res_d.pc = pc_i;
                    mis_d    = 1'b1;
                end else if (bad_f3) begin
                    res_d.pc = INVALID_PC;
                end else if (is_load) begin
                    res_d = '{rd: rd_addr_i, wreg: wreg_i, wdata: ld_val, pc: pc_i};
                end else begin
                    res_d = '{rd: rd_addr_i, wreg: 1'b0, wdata: wdata_i, pc: pc_i};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MEM_ST_IDLE;
            rdata_q <= '0;
            res_q   <= '{rd: 5'd0, wreg: 1'b0, wdata: 64'd0, pc: INVALID_PC};
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            res_q   <= res_d;
            mis_q   <= mis_d;
        end
    end

    assign rd_addr_o  = res_q.rd;
    assign wreg_o     = res_q.wreg;
    assign wdata_o    = res_q.wdata;
    assign pc_o       = res_q.pc;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a transaction-level expectation model
// and a per-cycle bus monitor.
module tb_mem_access;

    localparam logic [63:0] INV   = 64'h0;
    localparam logic [6:0]  LOAD  = 7'h03;
    localparam logic [6:0]  STORE = 7'h23;
    localparam logic [6:0]  ALU   = 7'h33;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic        wreg_i;
    logic [63:0] wdata_i, store_data_i, pc_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ready_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        stall_req_o;
    logic [4:0]  rd_addr_o;
    logic        wreg_o;
    logic [63:0] wdata_o, pc_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    logic        exp_bus_vld = 1'b0;
    logic        exp_we;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_strb;
    logic [7:0]  last_strb;
    logic [63:0] last_addr, last_wdata;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .store_data_i(store_data_i), .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_ready_i(dmem_ready_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_req_o(stall_req_o),
        .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o),
        .misalign_o(misalign_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Bus monitor: every request cycle must present the modelled address/lanes
    always @(negedge clk) begin
        if (dmem_req_o) begin
            last_addr  = dmem_addr_o;
            last_strb  = dmem_wstrb_o;
            last_wdata = dmem_wdata_o;
            chk("req_expected", exp_bus_vld, 1);
            if (exp_bus_vld) begin
                chk("bus_addr", dmem_addr_o, exp_addr);
                chk("bus_strb", dmem_wstrb_o, exp_strb);
                chk("bus_we", dmem_we_o, exp_we);
                if (exp_we) chk("bus_wdata", dmem_wdata_o, exp_wdata);
            end
        end
    end

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] f3, input int off);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + m_size(f3)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] sd);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[8*l +: 8] = sd[8*(l % m_size(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] rdat);
        logic [63:0] v, mask;
        int sz;
        if (f3[1:0] == 2'd3) return rdat;
        sz   = m_size(f3);
        v    = rdat >> (8 * off);
        mask = (64'h1 << (8 * sz)) - 64'h1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_bubble();
        opcode_i = ALU; funct3_i = 3'd0; pc_i = INV; rd_addr_i = 5'd0; wreg_i = 1'b0;
        wdata_i = 64'd0; store_data_i = 64'd0;
    endtask

    // Drives one EX/MEM instruction from a negedge, services the bus, checks
    // stall length, request count and the registered result.
    task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sd, input logic [63:0] rdat,
                          input int rdy_dly, input int rv_dly, input logic [63:0] pc,
                          input logic [4:0] rd, input logic wreg);
        logic ld, st, mem, bad, mis, e_wr, e_mis;
        logic [4:0]  e_rd;
        logic [63:0] e_wd, e_pc;
        int off, e_stall, stall_n, req_n, wait_n, c;
        ld = (op == LOAD); st = (op == STORE);
        mem = (ld || st) && (pc != INV);
        off = int'(addr[2:0]);
        bad = st && f3[2];
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = mem && !bad && ((off % m_size(f3)) != 0);
`endif
        e_mis = 1'b0;
        if (!mem) begin
            e_rd = rd; e_wr = wreg; e_wd = addr; e_pc = pc; e_stall = 0;
        end else if (bad) begin
            e_rd = 0; e_wr = 0; e_wd = 0; e_pc = INV; e_stall = 1;
        end else if (mis) begin
            e_rd = 0; e_wr = 0; e_wd = 0; e_pc = pc; e_stall = 1; e_mis = 1'b1;
        end else if (ld) begin
            e_rd = rd; e_wr = wreg; e_wd = m_load(f3, off, rdat); e_pc = pc;
            e_stall = 1 + (rdy_dly + 1) + (rv_dly + 1);
        end else begin
            e_rd = rd; e_wr = 0; e_wd = addr; e_pc = pc; e_stall = 1 + (rdy_dly + 1);
        end
        exp_addr = {addr[63:3], 3'b000}; exp_strb = m_strb(f3, off);
        exp_we = st; exp_wdata = m_wdata(f3, sd);
        exp_bus_vld = mem && !bad && !mis;

        opcode_i = op; funct3_i = f3; wdata_i = addr; store_data_i = sd;
        pc_i = pc; rd_addr_i = rd; wreg_i = wreg;
        stall_n = 0; req_n = 0; wait_n = 0; c = 0;
        #1;
        while (stall_req_o && c < 64) begin
            stall_n++;
            if (dmem_req_o) begin
                dmem_ready_i = (req_n == rdy_dly);
                req_n++;
            end else if (req_n > 0) begin
                dmem_ready_i  = 1'b0;
                dmem_rvalid_i = (wait_n == rv_dly);
                dmem_rdata_i  = rdat;
                wait_n++;
            end
            @(negedge clk);
            c++;
        end
        if (stall_req_o) chk({nm, "_timeout"}, stall_req_o, 0);
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk({nm, "_stall"}, stall_n, e_stall);
        chk({nm, "_reqs"}, req_n, exp_bus_vld ? rdy_dly + 1 : 0);
        @(posedge clk); #1;
        exp_bus_vld = 1'b0;
        set_bubble();
        @(negedge clk);
        chk({nm, "_rd"}, rd_addr_o, e_rd);
        chk({nm, "_wreg"}, wreg_o, e_wr);
        chk({nm, "_wdata"}, wdata_o, e_wd);
        chk({nm, "_pc"}, pc_o, e_pc);
        chk({nm, "_misalign"}, misalign_o, e_mis);
    endtask

    // Reset asserted while a load sits in REQ (in_wait=0) or WAIT (in_wait=1)
    task automatic reset_mid(input string nm, input bit in_wait);
        exp_addr = 64'h2010; exp_strb = 8'h0F; exp_we = 1'b0; exp_bus_vld = 1'b1;
        opcode_i = LOAD; funct3_i = 3'd2; wdata_i = 64'h2010; pc_i = 64'h900;
        rd_addr_i = 5'd3; wreg_i = 1'b1;
        @(negedge clk);
        dmem_ready_i = in_wait;
        if (in_wait) begin
            @(negedge clk);
            dmem_ready_i = 1'b0;
        end
        chk({nm, "_stall_before"}, stall_req_o, 1);
        chk({nm, "_req_before"}, dmem_req_o, !in_wait);
        #1;
        exp_bus_vld = 1'b0;
        rst = 1'b0;
        set_bubble();
        @(posedge clk); #1;
        chk({nm, "_req_drop"}, dmem_req_o, 0);
        chk({nm, "_stall_drop"}, stall_req_o, 0);
        rst = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk({nm, "_rd"}, rd_addr_o, 0);
        chk({nm, "_wreg"}, wreg_o, 0);
        chk({nm, "_wdata"}, wdata_o, 0);
        chk({nm, "_pc"}, pc_o, INV);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk({nm, "_late_rvalid_stall"}, stall_req_o, 0);
        chk({nm, "_late_rvalid_req"}, dmem_req_o, 0);
        chk({nm, "_late_rvalid_wdata"}, wdata_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'd0;
        opcode_i = ALU; funct3_i = 3'd0; pc_i = 64'h100; rd_addr_i = 5'd5;
        wreg_i = 1'b1; wdata_i = 64'h55; store_data_i = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_rd", rd_addr_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_pc", pc_o, INV);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_req", dmem_req_o, 0);
        rst = 1'b1;

        run_op("add", ALU, 3'd0, 64'h1234, 0, 0, 0, 0, 64'h104, 5'd5, 1'b1);
        chk("add_lit", wdata_o, 64'h1234);
        run_op("sb", STORE, 3'd0, 64'h1003, 64'hAB, 0, 0, 0, 64'h108, 5'd1, 1'b1);
        chk("sb_lit_strb", last_strb, 8'h08);
        chk("sb_lit_addr", last_addr, 64'h1000);
        chk("sb_lit_wdata", last_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        run_op("sh", STORE, 3'd1, 64'h1006, 64'h1234_BEEF, 0, 1, 0, 64'h10C, 5'd2, 1'b1);
        chk("sh_lit_wdata", last_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        run_op("sw", STORE, 3'd2, 64'h1004, 64'hDEAD_BEEF, 0, 0, 0, 64'h110, 5'd3, 1'b1);
        run_op("sd", STORE, 3'd3, 64'h1008, 64'h0123_4567_89AB_CDEF, 0, 2, 0, 64'h114, 5'd4, 1'b1);
        run_op("sh_off7", STORE, 3'd1, 64'h1007, 64'h00CC, 0, 0, 0, 64'h118, 5'd5, 1'b1);
        run_op("st_badf3", STORE, 3'd4, 64'h1010, 64'h77, 0, 0, 0, 64'h11C, 5'd6, 1'b1);
        run_op("lb", LOAD, 3'd0, 64'h2005, 0, 64'h0000_80FF_0000_0000, 2, 0, 64'h120, 5'd7, 1'b1);
        chk("lb_lit", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        run_op("lbu", LOAD, 3'd4, 64'h2005, 0, 64'h0000_80FF_0000_0000, 2, 0, 64'h124, 5'd8, 1'b1);
        chk("lbu_lit", wdata_o, 64'h80);
        run_op("lw", LOAD, 3'd2, 64'h2004, 0, 64'h8765_4321_0000_0000, 4, 1, 64'h128, 5'd9, 1'b1);
        chk("lw_lit", wdata_o, 64'hFFFF_FFFF_8765_4321);
        run_op("lwu", LOAD, 3'd6, 64'h2004, 0, 64'h8765_4321_0000_0000, 0, 0, 64'h12C, 5'd10, 1'b1);
        run_op("lh", LOAD, 3'd1, 64'h2002, 0, 64'h0000_0000_8001_0000, 0, 2, 64'h130, 5'd11, 1'b1);
        run_op("lhu", LOAD, 3'd5, 64'h2002, 0, 64'h0000_0000_8001_0000, 1, 0, 64'h134, 5'd12, 1'b1);
        run_op("ld", LOAD, 3'd3, 64'h2008, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h138, 5'd13, 1'b1);
        run_op("ld_f3_7", LOAD, 3'd7, 64'h2008, 0, 64'hFEDC_BA98_7654_3210, 0, 0, 64'h13C, 5'd14, 1'b1);
        run_op("ld_bubble_pc", LOAD, 3'd0, 64'h44, 0, 0, 0, 0, INV, 5'd9, 1'b1);
        run_op("lh_3001", LOAD, 3'd1, 64'h3001, 0, 64'h0000_0000_00AB_CD00, 0, 0, 64'h140, 5'd15, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("lh_3001_lit_misalign", misalign_o, 1);
        chk("lh_3001_lit_pc", pc_o, 64'h140);
`else
        chk("lh_3001_lit_strb", last_strb, 8'h06);
        chk("lh_3001_lit_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_ABCD);
`endif
        reset_mid("rst_wait", 1'b1);
        reset_mid("rst_req", 1'b0);
        run_op("post_rst_lbu", LOAD, 3'd4, 64'h2001, 0, 64'h0000_0000_0000_5A00, 0, 0, 64'h144, 5'd16, 1'b1);
        chk("post_rst_lit", wdata_o, 64'h5A);
        run_op("add2", ALU, 3'd0, 64'hCAFE, 0, 0, 0, 0, 64'h148, 5'd17, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
